clock_tick_controller: RTL and testbench
========================================

# clock_tick_controller

Timing and time-set front end for the digital clock. It divides the system clock into a one-second tick and drives the enable, clear and parallel-load inputs of the seconds, minutes and hours 6-bit counters. It produces the 59→0 and 23→0 wrap-arounds, since those counters count in plain binary. Two debounced push buttons let the user set hours and minutes through the counters' parallel-load path.

## Interface
- TICK_DIV, 50_000_000: clk cycles per one-second tick (≥2)
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles before a button level is accepted (≥1)
- REPEAT_CYCLES, 25_000_000: auto-repeat period while inc is held (used only with the macro)
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- btn_mode  in  1  raw mode button, asynchronous, active-high
- btn_inc  in  1  raw increment button, asynchronous, active-high
- sec_cnt  in  6  current seconds counter value
- min_cnt  in  6  current minutes counter value
- hr_cnt  in  6  current hours counter value (0–23)
- sec_en / min_en / hr_en  out  1  count enables, one-cycle pulses
- sec_clear / min_clear / hr_clear  out  1  counter clears, one-cycle pulses
- min_load / hr_load  out  1  parallel-load strobes, one-cycle pulses
- set_value  out  6  shared parallel-load data for min/hr counters
- mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN (11 never driven)

## Operation
- **Button path.** Each button passes through a 2-flop synchronizer and then a debounce counter. The debounced level toggles only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. A press event is a one-cycle pulse on the debounced rising edge.
- **State machine.** States are RUN, SET_HR and SET_MIN.
  - Each mode press moves RUN→SET_HR→SET_MIN→RUN.
  - If mode and inc press events occur in the same cycle, mode wins and the inc event is dropped.
- **RUN state.**
  - The prescaler counts 0..TICK_DIV-1 and a tick fires on the terminal count.
  - On a tick: sec_en=1. If sec_cnt==59, then sec_clear=1 and min_en=1.
  - If min_en is asserted and min_cnt==59: min_clear=1 and hr_en=1.
  - If hr_en is asserted and hr_cnt==23: hr_clear=1.
  - A clear is always asserted in the same cycle as its own enable, and clear overrides the counter's increment.
  - inc events are ignored.
- **SET_HR state.**
  - The prescaler is held at 0 and all en/clear outputs stay 0.
  - Each inc event drives one cycle of hr_load=1 with set_value = (hr_cnt≥23) ? 0 : hr_cnt+1.
- **SET_MIN state.** Same as SET_HR, but drives min_load with set_value = (min_cnt≥59) ? 0 : min_cnt+1.
- **Leaving SET_MIN to RUN.** sec_clear=1 for one cycle and the prescaler restarts at 0, so the first tick arrives TICK_DIV cycles later.
- **set_value when no load is active.** Holds 0. Arithmetic is 6-bit unsigned and out-of-range inputs (e.g. min_cnt=62) load 0.
- **Output exclusivity.** At most one of min_load/hr_load is high in any cycle. A load never coincides with any en or clear.

## Timing
- All outputs are registered.
  - The count-chain pulses (sec_en, sec_clear, min_en, min_clear, hr_en, hr_clear) assert in the cycle after the prescaler reaches TICK_DIV-1.
  - Load strobes assert in the cycle after the inc press event.
- Button-to-event latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle.
- Between RUN ticks the counters are stable, so compares sample sec_cnt/min_cnt/hr_cnt directly with no extra staging.
- Reset value of every output is 0 (mode=00).
- Reset also clears the prescaler, debounce counters, synchronizers, debounced levels and the repeat counter; state returns to RUN.
- Reset mid-debounce or mid-set discards any pending press.

## Configuration
- **`CLOCK_INC_AUTOREPEAT_EN` defined.** While the debounced inc level stays high in a SET state:
  - a repeat counter generates an additional inc event every REPEAT_CYCLES cycles after the initial press event;
  - the counter restarts on release and on each mode change.
- **Undefined.** One increment per press only. The repeat counter and its logic are not built.

## Test plan
All scenarios use TICK_DIV=4, DEBOUNCE_CYCLES=3, REPEAT_CYCLES=5.
- **Tick rollover.** Hold sec_cnt=58, min_cnt=59, hr_cnt=23 in RUN → sec_en pulses every 4 cycles with no clears. Then set sec_cnt=59 → the next tick asserts sec_en, sec_clear, min_en, min_clear, hr_en and hr_clear in one cycle.
- **Debounce.** Glitch btn_mode high for 2 cycles → mode stays 00. Hold it for 6 cycles → mode=01 exactly 2+3+1 cycles after the rise.
- **Hour set wrap.** In SET_HR with hr_cnt=23, press inc → one cycle of hr_load=1, set_value=0, with all en outputs 0. With hr_cnt=5 → set_value=6.
- **Exit to RUN.** SET_MIN with min_cnt=59, press inc → min_load with set_value=0. Then press mode → mode=00, one sec_clear pulse, first sec_en 4 cycles later.
- **Simultaneous events and reset.** Press mode and inc in the same cycle while in SET_HR → mode=10 and no hr_load. Assert reset for 1 cycle mid-SET_MIN → all outputs 0 and mode=00 on the next edge.
- **Auto-repeat (macro defined).** Hold inc for 20 cycles in SET_MIN → min_load pulses at the first event and then every 5 cycles. With the macro undefined → exactly one pulse.

Source files
------------

// File: rtl/clock_tick_controller.sv
// Digital clock timing and time-set front end: one-second prescaler, count-chain control and button-driven set.
// Optional hold-to-repeat for the inc button is built when CLOCK_INC_AUTOREPEAT_EN is defined.
module clock_tick_controller #(
   parameter int TICK_DIV        = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_CYCLES   = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [5:0] sec_cnt,
   input  logic [5:0] min_cnt,
   input  logic [5:0] hr_cnt,
   output logic       sec_en,
   output logic       min_en,
   output logic       hr_en,
   output logic       sec_clear,
   output logic       min_clear,
   output logic       hr_clear,
   output logic       min_load,
   output logic       hr_load,
   output logic [5:0] set_value,
   output logic [1:0] mode
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
      $error("clock_tick_controller: illegal parameter value");
   end

   typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10} state_t;

   state_t          state;
   logic [PW-1:0]   presc;
   logic [1:0]      sync1, sync2, deb, deb_q;
   logic [DW-1:0]   deb_cnt [2];
   logic [1:0]      press;
   logic            mode_evt, inc_press, inc_evt;

   // Bit 0 is the mode button, bit 1 the inc button.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1      <= '0;
         sync2      <= '0;
         deb        <= '0;
         deb_q      <= '0;
         deb_cnt[0] <= '0;
         deb_cnt[1] <= '0;
      end else begin
         sync1 <= {btn_inc, btn_mode};
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != deb[i]) begin
               if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                  deb[i]     <= sync2[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 1'b1;
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   assign press     = deb & ~deb_q;
   assign mode_evt  = press[0];
   assign inc_press = press[1] & ~press[0];

`ifdef CLOCK_INC_AUTOREPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   logic [RW-1:0] rep_cnt;
   logic          rep_hit;

   assign rep_hit = (state != RUN) && deb[1] && !mode_evt && (rep_cnt == RW'(REPEAT_CYCLES - 1));
   assign inc_evt = inc_press | rep_hit;

   // Phase is anchored to the initial press; release or any mode change restarts it.
   always_ff @(posedge clk) begin
      if (reset) begin
         rep_cnt <= '0;
      end else if (state == RUN || !deb[1] || mode_evt || inc_press || rep_hit) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt + 1'b1;
      end
   end
`else
   assign inc_evt = inc_press;
`endif

   assign mode = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         presc     <= '0;
         sec_en    <= 1'b0;
         min_en    <= 1'b0;
         hr_en     <= 1'b0;
         sec_clear <= 1'b0;
         min_clear <= 1'b0;
         hr_clear  <= 1'b0;
         min_load  <= 1'b0;
         hr_load   <= 1'b0;
         set_value <= '0;
      end else begin
         sec_en    <= 1'b0;
         min_en    <= 1'b0;
         hr_en     <= 1'b0;
         sec_clear <= 1'b0;
         min_clear <= 1'b0;
         hr_clear  <= 1'b0;
         min_load  <= 1'b0;
         hr_load   <= 1'b0;
         set_value <= '0;
         case (state)
            RUN: begin
               if (mode_evt) begin
                  state <= SET_HR;
                  presc <= '0;
               end else if (presc == PW'(TICK_DIV - 1)) begin
                  // Each clear rides with its own enable so the counter wraps instead of incrementing.
                  presc     <= '0;
                  sec_en    <= 1'b1;
                  sec_clear <= (sec_cnt == 6'd59);
                  min_en    <= (sec_cnt == 6'd59);
                  min_clear <= (sec_cnt == 6'd59) && (min_cnt == 6'd59);
                  hr_en     <= (sec_cnt == 6'd59) && (min_cnt == 6'd59);
                  hr_clear  <= (sec_cnt == 6'd59) && (min_cnt == 6'd59) && (hr_cnt == 6'd23);
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            SET_HR: begin
               presc <= '0;
               if (mode_evt) begin
                  state <= SET_MIN;
               end else if (inc_evt) begin
                  hr_load   <= 1'b1;
                  set_value <= (hr_cnt >= 6'd23) ? 6'd0 : hr_cnt + 6'd1;
               end
            end
            SET_MIN: begin
               presc <= '0;
               if (mode_evt) begin
                  state     <= RUN;
                  sec_clear <= 1'b1;
               end else if (inc_evt) begin
                  min_load  <= 1'b1;
                  set_value <= (min_cnt >= 6'd59) ? 6'd0 : min_cnt + 6'd1;
               end
            end
            default: begin
               state <= RUN;
               presc <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clock_tick_controller.sv
// Directed bench for clock_tick_controller with TICK_DIV=4, DEBOUNCE_CYCLES=3, REPEAT_CYCLES=5.
// Observed vector layout: {sec_en, sec_clear, min_en, min_clear, hr_en, hr_clear, min_load, hr_load, set_value, mode}.
module tb_clock_tick_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_mode, btn_inc;
   logic [5:0] sec_cnt, min_cnt, hr_cnt;
   logic       sec_en, min_en, hr_en, sec_clear, min_clear, hr_clear;
   logic       min_load, hr_load;
   logic [5:0] set_value;
   logic [1:0] mode;
   logic [15:0] obs_vec;

   int vectors = 0;
   int miscompares = 0;
   int pulses;
   int exp_pulses;

   clock_tick_controller #(
      .TICK_DIV(4), .DEBOUNCE_CYCLES(3), .REPEAT_CYCLES(5)
   ) dut (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .sec_cnt(sec_cnt), .min_cnt(min_cnt), .hr_cnt(hr_cnt),
      .sec_en(sec_en), .min_en(min_en), .hr_en(hr_en),
      .sec_clear(sec_clear), .min_clear(min_clear), .hr_clear(hr_clear),
      .min_load(min_load), .hr_load(hr_load), .set_value(set_value), .mode(mode)
   );

   always #5 clk = ~clk;

   assign obs_vec = {sec_en, sec_clear, min_en, min_clear, hr_en, hr_clear,
                     min_load, hr_load, set_value, mode};

   function automatic logic [15:0] mk(input logic [5:0] chain, input logic [1:0] loads,
                                      input logic [5:0] sv, input logic [1:0] m);
      return {chain, loads, sv, m};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic press_mode();
      btn_mode = 1'b1;
      step(6);
      btn_mode = 1'b0;
      step(6);
   endtask

   // Press inc and check the output vector the cycle before, of, and after the expected load.
   task automatic inc_check(input string tag, input logic [15:0] exp, input logic [1:0] m);
      btn_inc = 1'b1;
      step(5);
      check({tag, "_before"}, obs_vec, mk(6'b0, 2'b00, 6'd0, m));
      step(1);
      check(tag, obs_vec, exp);
      step(1);
      check({tag, "_after"}, obs_vec, mk(6'b0, 2'b00, 6'd0, m));
      btn_inc = 1'b0;
      step(6);
   endtask

   initial begin
      reset    = 1'b1;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      sec_cnt  = 6'd58;
      min_cnt  = 6'd59;
      hr_cnt   = 6'd23;
      step(2);
      check("reset_state", obs_vec, 16'h0000);
      reset = 1'b0;

      // Tick cadence without wrap, then full rollover once seconds reach 59.
      for (int k = 1; k <= 12; k++) begin
         step(1);
         if (k % 4 != 0)
            check($sformatf("tick_idle_%0d", k), obs_vec, 16'h0000);
         else if (k < 12)
            check($sformatf("tick_plain_%0d", k), obs_vec, mk(6'b100000, 2'b00, 6'd0, 2'b00));
         else
            check("tick_rollover", obs_vec, mk(6'b111111, 2'b00, 6'd0, 2'b00));
         if (k == 8) sec_cnt = 6'd59;
      end
      sec_cnt = 6'd0;

      // Short glitch must be rejected, a held press accepted after 2+3+1 cycles.
      btn_mode = 1'b1;
      step(2);
      btn_mode = 1'b0;
      step(8);
      check("glitch_mode", {14'd0, mode}, 16'd0);
      btn_mode = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step(1);
         check($sformatf("debounce_mode_%0d", i), {14'd0, mode}, (i == 6) ? 16'd1 : 16'd0);
      end
      btn_mode = 1'b0;
      step(6);

      hr_cnt = 6'd23;
      inc_check("hr_wrap", mk(6'b0, 2'b01, 6'd0, 2'b01), 2'b01);
      hr_cnt = 6'd5;
      inc_check("hr_inc", mk(6'b0, 2'b01, 6'd6, 2'b01), 2'b01);
      hr_cnt = 6'd30;
      inc_check("hr_out_of_range", mk(6'b0, 2'b01, 6'd0, 2'b01), 2'b01);

      // Mode and inc pressed together: mode wins, no load.
      hr_cnt   = 6'd5;
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      step(6);
      check("simul_mode_wins", obs_vec, mk(6'b0, 2'b00, 6'd0, 2'b10));
      step(1);
      check("simul_no_load", obs_vec, mk(6'b0, 2'b00, 6'd0, 2'b10));
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step(6);

      min_cnt = 6'd59;
      inc_check("min_wrap", mk(6'b0, 2'b10, 6'd0, 2'b10), 2'b10);
      min_cnt = 6'd62;
      inc_check("min_out_of_range", mk(6'b0, 2'b10, 6'd0, 2'b10), 2'b10);
      min_cnt = 6'd7;
      inc_check("min_inc", mk(6'b0, 2'b10, 6'd8, 2'b10), 2'b10);

      // Hold inc for 20 cycles and count load strobes.
      min_cnt = 6'd10;
      pulses  = 0;
      btn_inc = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step(1);
         if (min_load) pulses++;
         if (k == 20) btn_inc = 1'b0;
      end
`ifdef CLOCK_INC_AUTOREPEAT_EN
      exp_pulses = 4;
`else
      exp_pulses = 1;
`endif
      check("hold_inc_pulses", 16'(pulses), 16'(exp_pulses));

      // Leaving SET_MIN: one sec_clear, then first tick 4 cycles later.
      btn_mode = 1'b1;
      step(6);
      check("exit_sec_clear", obs_vec, mk(6'b010000, 2'b00, 6'd0, 2'b00));
      btn_mode = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step(1);
         check($sformatf("exit_tick_%0d", k), obs_vec,
               (k == 4) ? mk(6'b100000, 2'b00, 6'd0, 2'b00) : 16'h0000);
      end
      step(6);

      // Reset in the middle of SET_MIN with an inc press pending.
      press_mode();
      press_mode();
      check("reenter_set_min", {14'd0, mode}, 16'd2);
      btn_inc = 1'b1;
      step(3);
      reset = 1'b1;
      step(1);
      check("reset_mid_set", obs_vec, 16'h0000);
      reset   = 1'b0;
      btn_inc = 1'b0;
      step(7);
      check("after_reset_idle", obs_vec, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
